// File: rtl/key_event_encoder.sv
// Piano input front end: synchronizes and debounces notes/buttons, turns level
// changes into key events and queues them for the mode controller.
module key_event_encoder #(
    parameter int TICK_CYCLES    = 100000,
    parameter int STABLE_SAMPLES = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] note_raw,
    input  logic       submit_raw,
    input  logic       cancel_raw,
    input  logic       up_raw,
    input  logic       down_raw,
    output logic [6:0] note_stable,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_kind,
    output logic [2:0] evt_index,
    output logic       overflow
);
    localparam int NIN   = 11;
    localparam int NFLAG = 18;
    localparam int TW    = $clog2(TICK_CYCLES);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    logic [NIN-1:0]            raw, sync1, sync2, stable, stable_next;
    logic [STABLE_SAMPLES-1:0] samp      [NIN];
    logic [STABLE_SAMPLES-1:0] samp_next [NIN];
    logic [TW-1:0]             tick_cnt;
    logic                      tick;
    logic [NFLAG-1:0]          pending, flag_set, grant;
    logic [2:0]                fifo_kind  [FIFO_DEPTH];
    logic [2:0]                fifo_index [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count;
    logic                      pop, push, can_push, arb_hit;
    logic [2:0]                push_kind, push_index;

    // bit map: 0..6 notes, 7 submit, 8 cancel, 9 up, 10 down
    assign raw  = {down_raw, up_raw, cancel_raw, submit_raw, note_raw};
    assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

    // flag map: 0..6 note press, 7..13 note release, 14 submit, 15 cancel, 16 up, 17 down
    always_comb begin
        stable_next = stable;
        flag_set    = '0;
        for (int i = 0; i < NIN; i++) begin
            samp_next[i] = samp[i];
            if (tick) begin
                samp_next[i] = {samp[i][STABLE_SAMPLES-2:0], sync2[i]};
                if (&samp_next[i] && !stable[i])
                    stable_next[i] = 1'b1;
                else if (~|samp_next[i] && stable[i])
                    stable_next[i] = 1'b0;
            end
        end
        for (int n = 0; n < 7; n++) begin
            flag_set[n]     = stable_next[n] & ~stable[n];
            flag_set[7 + n] = ~stable_next[n] & stable[n];
        end
        for (int b = 0; b < 4; b++)
            flag_set[14 + b] = stable_next[7 + b] & ~stable[7 + b];
    end

    assign evt_valid = (count != '0);
    assign pop       = evt_valid & evt_ready;
    assign can_push  = (count < CW'(FIFO_DEPTH)) || pop;
    assign push      = |grant;

    always_comb begin
        grant      = '0;
        push_kind  = 3'd0;
        push_index = 3'd0;
        arb_hit    = 1'b0;
        if (can_push) begin
            if (pending[15]) begin
                grant[15] = 1'b1; push_kind = 3'd3; arb_hit = 1'b1;
            end else if (pending[14]) begin
                grant[14] = 1'b1; push_kind = 3'd2; arb_hit = 1'b1;
            end else if (pending[16]) begin
                grant[16] = 1'b1; push_kind = 3'd4; arb_hit = 1'b1;
            end else if (pending[17]) begin
                grant[17] = 1'b1; push_kind = 3'd5; arb_hit = 1'b1;
            end
            for (int n = 0; n < 14; n++) begin
                if (!arb_hit && pending[n]) begin
                    grant[n]   = 1'b1;
                    arb_hit    = 1'b1;
                    push_kind  = (n < 7) ? 3'd0 : 3'd1;
                    push_index = (n < 7) ? 3'(n) : 3'(n - 7);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            tick_cnt <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < NIN; i++)
                samp[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable   <= stable_next;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            for (int i = 0; i < NIN; i++)
                samp[i] <= samp_next[i];
            // a flag granted this cycle is free to take a new event without merging
            pending <= (pending & ~grant) | flag_set;
            if (|(flag_set & pending & ~grant))
                overflow <= 1'b1;
            if (push) begin
                fifo_kind[wr_ptr]  <= push_kind;
                fifo_index[wr_ptr] <= push_index;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign note_stable = stable[6:0];
    assign evt_kind    = evt_valid ? fifo_kind[rd_ptr]  : 3'd0;
    assign evt_index   = evt_valid ? fifo_index[rd_ptr] : 3'd0;
endmodule
